// File: rtl/wb_pkg.sv
// Shared widths and FSM state type for the Wishbone-to-SRAM responder.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      CAPTURE,
      RESP
   } state_e;

endpackage

// File: rtl/wb_sram_ctrl.sv
// SRAM control driver: turns the latched Wishbone request into one-cycle SRAM strobes.
module wb_sram_ctrl
   import wb_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic                 access_i,
   input  logic                 hit_i,
   input  logic                 we_i,
   input  logic [WB_SEL_W-1:0]  sel_i,
   input  logic [ADDR_W-1:0]    adr_i,
   input  logic [WB_DATA_W-1:0] dat_i,
   output logic                 sram_csb_o,
   output logic                 sram_web_o,
   output logic [WB_SEL_W-1:0]  sram_wmask_o,
   output logic [ADDR_W-1:0]    sram_addr_o,
   output logic [WB_DATA_W-1:0] sram_din_o
);

   // Out-of-range or empty-select requests leave the macro completely idle.
   always_comb begin
      sram_csb_o   = 1'b1;
      sram_web_o   = 1'b1;
      sram_wmask_o = '0;
      sram_addr_o  = '0;
      sram_din_o   = '0;
      if (access_i && hit_i && (sel_i != '0)) begin
         sram_csb_o   = 1'b0;
         sram_web_o   = !we_i;
         sram_wmask_o = sel_i;
         sram_addr_o  = adr_i;
         sram_din_o   = dat_i;
      end
   end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone slave fronting a single-port SRAM macro with a fixed 3-cycle request-to-ack latency.
// Define WB_SRAM_RESP_ERR_EN to answer out-of-range addresses with wb_err_o instead of wb_ack_o.
module wb_sram_responder
   import wb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_n,
   input  logic [WB_DATA_W-1:0] wb_dat_i,
   input  logic [ADDR_W-1:0]    wb_adr_i,
   input  logic [WB_SEL_W-1:0]  wb_sel_i,
   input  logic                 wb_we_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   output logic [WB_DATA_W-1:0] wb_dat_o,
   output logic                 wb_ack_o,
`ifdef WB_SRAM_RESP_ERR_EN
   output logic                 wb_err_o,
`endif
   output logic                 sram_csb_o,
   output logic                 sram_web_o,
   output logic [WB_SEL_W-1:0]  sram_wmask_o,
   output logic [ADDR_W-1:0]    sram_addr_o,
   output logic [WB_DATA_W-1:0] sram_din_o,
   input  logic [WB_DATA_W-1:0] sram_dout_i
);

   state_e               state_q, state_d;
   logic                 accept;
   logic                 respSlot;
   logic [ADDR_W-1:0]    reqAdr_q;
   logic [WB_DATA_W-1:0] reqDat_q;
   logic [WB_SEL_W-1:0]  reqSel_q;
   logic                 reqWe_q;
   logic                 reqHit_q;
   logic [WB_DATA_W-1:0] rdData_q;

   // Dropping cyc during the response slot cancels the ack in the same cycle.
   assign respSlot = (state_q == RESP) && wb_cyc_i;
`ifdef WB_SRAM_RESP_ERR_EN
   assign wb_ack_o = respSlot && reqHit_q;
   assign wb_err_o = respSlot && !reqHit_q;
`else
   assign wb_ack_o = respSlot;
`endif
   assign wb_dat_o = rdData_q;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
               accept  = 1'b1;
               state_d = ACCESS;
            end
         end
         ACCESS:  state_d = wb_cyc_i ? CAPTURE : IDLE;
         CAPTURE: state_d = wb_cyc_i ? RESP : IDLE;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // The request is frozen at acceptance so later stb/dat wiggles cannot leak in.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         reqAdr_q <= '0;
         reqDat_q <= '0;
         reqSel_q <= '0;
         reqWe_q  <= 1'b0;
         reqHit_q <= 1'b0;
      end else if (accept) begin
         reqAdr_q <= wb_adr_i;
         reqDat_q <= wb_dat_i;
         reqSel_q <= wb_sel_i;
         reqWe_q  <= wb_we_i;
         reqHit_q <= (32'(wb_adr_i) < DEPTH);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rdData_q <= '0;
      end else if ((state_q == CAPTURE) && wb_cyc_i && !reqWe_q) begin
`ifdef WB_SRAM_RESP_ERR_EN
         if (reqHit_q) begin
            rdData_q <= (reqSel_q != '0) ? sram_dout_i : '0;
         end
`else
         rdData_q <= (reqHit_q && (reqSel_q != '0)) ? sram_dout_i : '0;
`endif
      end
   end

   wb_sram_ctrl #(
      .ADDR_W(ADDR_W)
   ) uCtrl (
      .access_i    (state_q == ACCESS),
      .hit_i       (reqHit_q),
      .we_i        (reqWe_q),
      .sel_i       (reqSel_q),
      .adr_i       (reqAdr_q),
      .dat_i       (reqDat_q),
      .sram_csb_o  (sram_csb_o),
      .sram_web_o  (sram_web_o),
      .sram_wmask_o(sram_wmask_o),
      .sram_addr_o (sram_addr_o),
      .sram_din_o  (sram_din_o)
   );

endmodule

// File: tb/tb_wb_sram_responder.sv
// Directed bench for wb_sram_responder (DEPTH=128) with a byte-masked SRAM model.
// Define WB_SRAM_RESP_ERR_EN to exercise the error-response variant.
module tb_wb_sram_responder;
   import wb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] wb_dat_i;
   logic [7:0]  wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
`ifdef WB_SRAM_RESP_ERR_EN
   logic        wb_err_o;
`endif
   logic        sram_csb_o;
   logic        sram_web_o;
   logic [3:0]  sram_wmask_o;
   logic [7:0]  sram_addr_o;
   logic [31:0] sram_din_o;
   logic [31:0] sramDout;

   logic [31:0] sramMem [0:127];

   int compareCount = 0;
   int failCount    = 0;
   int ackCount     = 0;
   int selCount     = 0;
   int ackBase;
   int selBase;
   int lat;
   logic [31:0] rd;
   logic        errSeen;
   logic        accCsb;
   logic        accWeb;
   logic [3:0]  accWmask;
   logic [7:0]  accAddr;
   logic [31:0] accDin;

   wb_sram_responder #(
      .ADDR_W(8),
      .DEPTH (128)
   ) dut (
      .clk_i       (clk),
      .rst_n       (rst_n),
      .wb_dat_i    (wb_dat_i),
      .wb_adr_i    (wb_adr_i),
      .wb_sel_i    (wb_sel_i),
      .wb_we_i     (wb_we_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_stb_i    (wb_stb_i),
      .wb_dat_o    (wb_dat_o),
      .wb_ack_o    (wb_ack_o),
`ifdef WB_SRAM_RESP_ERR_EN
      .wb_err_o    (wb_err_o),
`endif
      .sram_csb_o  (sram_csb_o),
      .sram_web_o  (sram_web_o),
      .sram_wmask_o(sram_wmask_o),
      .sram_addr_o (sram_addr_o),
      .sram_din_o  (sram_din_o),
      .sram_dout_i (sramDout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM macro model: synchronous read data one cycle after select, byte-masked writes.
   always @(posedge clk) begin
      if (!sram_csb_o) begin
         if (!sram_web_o) begin
            for (int b = 0; b < 4; b++) begin
               if (sram_wmask_o[b]) sramMem[sram_addr_o[6:0]][b*8 +: 8] <= sram_din_o[b*8 +: 8];
            end
         end else begin
            sramDout <= sramMem[sram_addr_o[6:0]];
         end
      end
   end

   always @(negedge clk) begin
      if (wb_ack_o) ackCount++;
      if (!sram_csb_o) selCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One Wishbone transfer; stb drops after the response, cyc stays high.
   task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, output int latency, output logic [31:0] rdata);
      @(posedge clk); #1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      latency  = 0;
      rdata    = 32'h0;
      errSeen  = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            accCsb   = sram_csb_o;
            accWeb   = sram_web_o;
            accWmask = sram_wmask_o;
            accAddr  = sram_addr_o;
            accDin   = sram_din_o;
            wb_dat_i = ~dat;
         end
         if (wb_ack_o) begin
            latency = i;
            rdata   = wb_dat_o;
            break;
         end
`ifdef WB_SRAM_RESP_ERR_EN
         if (wb_err_o) begin
            latency = i;
            rdata   = wb_dat_o;
            errSeen = 1'b1;
            break;
         end
`endif
      end
      wb_stb_i = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         wb_cyc_i = 1'b0;
         wb_stb_i = 1'b0;
      end
   endtask

   initial begin
      rst_n    = 1'b1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_adr_i = 8'h0;
      wb_dat_i = 32'h0;
      wb_sel_i = 4'h0;
      for (int i = 0; i < 128; i++) sramMem[i] = 32'h0;
      sramMem[0] = 32'hA0A0A0A0;
      sramMem[1] = 32'hB1B1B1B1;
      sramMem[2] = 32'hC2C2C2C2;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ack",   {31'b0, wb_ack_o},   32'h0);
      checkOutput("rst_dat",   wb_dat_o,            32'h0);
      checkOutput("rst_csb",   {31'b0, sram_csb_o}, 32'h1);
      checkOutput("rst_web",   {31'b0, sram_web_o}, 32'h1);
      checkOutput("rst_wmask", {28'b0, sram_wmask_o}, 32'h0);
      checkOutput("rst_addr",  {24'b0, sram_addr_o},  32'h0);
      checkOutput("rst_din",   sram_din_o,          32'h0);
`ifdef WB_SRAM_RESP_ERR_EN
      checkOutput("rst_err",   {31'b0, wb_err_o},   32'h0);
`endif
      rst_n = 1'b1;

      // Full-word write then read back.
      ackBase = ackCount;
      applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, lat, rd);
      checkOutput("wr10_latency", 32'(lat), 32'd3);
      checkOutput("wr10_csb",   {31'b0, accCsb},  32'h0);
      checkOutput("wr10_web",   {31'b0, accWeb},  32'h0);
      checkOutput("wr10_wmask", {28'b0, accWmask}, 32'hF);
      checkOutput("wr10_addr",  {24'b0, accAddr},  32'h10);
      checkOutput("wr10_din",   accDin, 32'hDEADBEEF);
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, lat, rd);
      checkOutput("rd10_latency", 32'(lat), 32'd3);
      checkOutput("rd10_web",   {31'b0, accWeb}, 32'h1);
      checkOutput("rd10_data",  rd, 32'hDEADBEEF);
      idleCycles(3);
      checkOutput("rd10_ack_count", 32'(ackCount - ackBase), 32'd2);

      // Byte-lane masked write.
      applyStimulus(1'b1, 8'h20, 32'h11223344, 4'hF, lat, rd);
      applyStimulus(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, lat, rd);
      checkOutput("wr20_wmask", {28'b0, accWmask}, 32'h5);
      applyStimulus(1'b0, 8'h20, 32'h0, 4'hF, lat, rd);
      checkOutput("rd20_data", rd, 32'h11BB33DD);
      idleCycles(2);

      // Back-to-back reads, next request offered the cycle after each ack.
      ackBase = ackCount;
      selBase = selCount;
      applyStimulus(1'b0, 8'h00, 32'h0, 4'hF, lat, rd);
      checkOutput("b2b0_latency", 32'(lat), 32'd3);
      checkOutput("b2b0_data", rd, 32'hA0A0A0A0);
      applyStimulus(1'b0, 8'h01, 32'h0, 4'hF, lat, rd);
      checkOutput("b2b1_latency", 32'(lat), 32'd3);
      checkOutput("b2b1_data", rd, 32'hB1B1B1B1);
      applyStimulus(1'b0, 8'h02, 32'h0, 4'hF, lat, rd);
      checkOutput("b2b2_latency", 32'(lat), 32'd3);
      checkOutput("b2b2_data", rd, 32'hC2C2C2C2);
      idleCycles(3);
      checkOutput("b2b_ack_count", 32'(ackCount - ackBase), 32'd3);
      checkOutput("b2b_sel_count", 32'(selCount - selBase), 32'd3);

      // Empty byte select: acked, SRAM never selected.
      selBase = selCount;
      applyStimulus(1'b1, 8'h30, 32'h12345678, 4'h0, lat, rd);
      checkOutput("sel0_latency", 32'(lat), 32'd3);
      idleCycles(2);
      checkOutput("sel0_sel_count", 32'(selCount - selBase), 32'd0);

      // Out-of-range read.
      ackBase = ackCount;
      selBase = selCount;
      applyStimulus(1'b0, 8'h80, 32'h0, 4'hF, lat, rd);
`ifdef WB_SRAM_RESP_ERR_EN
      checkOutput("oor_err_seen", {31'b0, errSeen}, 32'h1);
      checkOutput("oor_latency", 32'(lat), 32'd3);
      checkOutput("oor_dat_hold", rd, 32'hC2C2C2C2);
      idleCycles(2);
      checkOutput("oor_ack_count", 32'(ackCount - ackBase), 32'd0);
`else
      checkOutput("oor_latency", 32'(lat), 32'd3);
      checkOutput("oor_data", rd, 32'h0);
      idleCycles(2);
      checkOutput("oor_ack_count", 32'(ackCount - ackBase), 32'd1);
`endif
      checkOutput("oor_sel_count", 32'(selCount - selBase), 32'd0);

      // Abort by dropping cyc in CAPTURE, then a normal request.
      applyStimulus(1'b1, 8'h40, 32'h55667788, 4'hF, lat, rd);
      idleCycles(2);
      ackBase = ackCount;
      @(posedge clk); #1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b0;
      wb_adr_i = 8'h10;
      wb_sel_i = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      applyStimulus(1'b0, 8'h40, 32'h0, 4'hF, lat, rd);
      checkOutput("abort_next_latency", 32'(lat), 32'd3);
      checkOutput("abort_next_data", rd, 32'h55667788);
      idleCycles(3);
      checkOutput("abort_ack_count", 32'(ackCount - ackBase), 32'd1);

      // Reset asserted during ACCESS of a write.
      @(posedge clk); #1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = 1'b1;
      wb_adr_i = 8'h10;
      wb_dat_i = 32'h0BADF00D;
      wb_sel_i = 4'hF;
      @(posedge clk); #1;
      checkOutput("midrst_pre_csb", {31'b0, sram_csb_o}, 32'h0);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_csb",  {31'b0, sram_csb_o}, 32'h1);
      checkOutput("midrst_web",  {31'b0, sram_web_o}, 32'h1);
      checkOutput("midrst_ack",  {31'b0, wb_ack_o},   32'h0);
      checkOutput("midrst_dat",  wb_dat_o, 32'h0);
      checkOutput("midrst_addr", {24'b0, sram_addr_o}, 32'h0);
      checkOutput("midrst_din",  sram_din_o, 32'h0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      ackBase  = ackCount;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      checkOutput("midrst_ack_count", 32'(ackCount - ackBase), 32'd0);
      applyStimulus(1'b0, 8'h40, 32'h0, 4'hF, lat, rd);
      checkOutput("midrst_rd40", rd, 32'h55667788);
      applyStimulus(1'b0, 8'h10, 32'h0, 4'hF, lat, rd);
      checkOutput("midrst_rd10", rd, 32'hDEADBEEF);
      idleCycles(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
